// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: IDLE/RUN/HALT control, program counter
// with forward/backward branches, and a saturating RUN cycle counter.
module fetch_unit #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [PC_W-1:0]  start_addr_i,
    input  logic [7:0]       imem_data_i,
    input  logic             branchf_i,
    input  logic             branchb_i,
    input  logic [7:0]       offset_i,
    input  logic             done_i,
    output logic [PC_W-1:0]  imem_addr_o,
    output logic [7:0]       instruction_o,
    output logic             running_o,
    output logic             done_o,
    output logic [PC_W-1:0]  pc_o,
    output logic [CNT_W-1:0] cycle_count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [7:0]       HALT_INSN = 8'h88;
    localparam logic [PC_W-1:0]  PC_ONE    = PC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_next;
    logic [PC_W-1:0]  off_ext;
    logic [CNT_W-1:0] cycle_count;

    // Branch distance zero-extended to pc width; sums wrap naturally.
    always_comb begin
        off_ext = PC_W'(offset_i);
    end

    // Next pc while running; halt beats branches, forward beats backward.
    always_comb begin
        pc_next = pc + PC_ONE;
        if (done_i) begin
            pc_next = pc;
        end else if (branchf_i) begin
            pc_next = pc + off_ext;
        end else if (branchb_i) begin
            pc_next = pc - off_ext;
        end
    end

    // Control FSM with pc, cycle counter and registered state decodes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            pc          <= '0;
            cycle_count <= '0;
            running_o   <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start_i) begin
                        state       <= RUN;
                        pc          <= start_addr_i;
                        cycle_count <= '0;
                        running_o   <= 1'b1;
                        done_o      <= 1'b0;
                    end
                end
                RUN: begin
                    pc <= pc_next;
                    if (cycle_count != CNT_MAX) begin
                        cycle_count <= cycle_count + CNT_ONE;
                    end
                    if (done_i) begin
                        state     <= HALT;
                        running_o <= 1'b0;
                        done_o    <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    running_o <= 1'b0;
                    done_o    <= 1'b0;
                end
            endcase
        end
    end

    // Memory address and pc are the live register; halt opcode outside RUN.
    always_comb begin
        imem_addr_o   = pc;
        pc_o          = pc;
        cycle_count_o = cycle_count;
        instruction_o = running_o ? imem_data_i : HALT_INSN;
    end

    // RUN and HALT indications are mutually exclusive.
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(running_o && done_o))
                else $error("running_o and done_o both high");
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a cycle-level behavioural model.
// A second instance with a 4-bit counter shares all inputs for saturation.
module tb_fetch_unit;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic [9:0] start_addr_i;
    logic [7:0] imem_data_i;
    logic       branchf_i;
    logic       branchb_i;
    logic [7:0] offset_i;
    logic       done_i;

    logic [9:0]  imem_addr_o, pc_o;
    logic [7:0]  instruction_o;
    logic        running_o, done_o;
    logic [15:0] cycle_count_o;

    logic [9:0]  s_addr, s_pc;
    logic [7:0]  s_insn;
    logic        s_run, s_done;
    logic [3:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    // Model state
    bit m_run, m_halt;
    int m_pc, m_cnt, m_cnt4;

    always #5 clk_i = ~clk_i;

    fetch_unit #(.PC_W(10), .CNT_W(16)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
        .start_addr_i(start_addr_i), .imem_data_i(imem_data_i),
        .branchf_i(branchf_i), .branchb_i(branchb_i),
        .offset_i(offset_i), .done_i(done_i),
        .imem_addr_o(imem_addr_o), .instruction_o(instruction_o),
        .running_o(running_o), .done_o(done_o), .pc_o(pc_o),
        .cycle_count_o(cycle_count_o)
    );

    fetch_unit #(.PC_W(10), .CNT_W(4)) dut4 (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
        .start_addr_i(start_addr_i), .imem_data_i(imem_data_i),
        .branchf_i(branchf_i), .branchb_i(branchb_i),
        .offset_i(offset_i), .done_i(done_i),
        .imem_addr_o(s_addr), .instruction_o(s_insn),
        .running_o(s_run), .done_o(s_done), .pc_o(s_pc),
        .cycle_count_o(s_cnt)
    );

    task automatic idle_inputs();
        start_i   = 1'b0;
        branchf_i = 1'b0;
        branchb_i = 1'b0;
        done_i    = 1'b0;
        offset_i  = 8'd0;
        imem_data_i = 8'($urandom_range(0, 255));
    endtask

    task automatic model_reset();
        m_run = 0; m_halt = 0; m_pc = 0; m_cnt = 0; m_cnt4 = 0;
    endtask

    // Advance model by one clock from the current inputs, then the DUT.
    task automatic tick();
        if (!m_run) begin
            if (start_i) begin
                m_run = 1; m_halt = 0;
                m_pc = int'(start_addr_i);
                m_cnt = 0; m_cnt4 = 0;
            end
        end else begin
            m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
            m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : 15;
            if (done_i) begin
                m_run = 0; m_halt = 1;
            end else if (branchf_i) begin
                m_pc = (m_pc + int'(offset_i)) % 1024;
            end else if (branchb_i) begin
                m_pc = (m_pc + 1024 - int'(offset_i)) % 1024;
            end else begin
                m_pc = (m_pc + 1) % 1024;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        start_addr_i = 10'h000;
        reset_i = 1'b1;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        checks++;
        if (pc_o !== 10'h000 || imem_addr_o !== 10'h000) begin
            errors++;
            $display("FAIL reset_pc got %h/%h want 000", pc_o, imem_addr_o);
        end
        checks++;
        if (running_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got run=%b done=%b want 0/0",
                     running_o, done_o);
        end
        checks++;
        if (instruction_o !== 8'h88 || cycle_count_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_insn_cnt got %h/%0d want 88/0",
                     instruction_o, cycle_count_o);
        end
    endtask

    task automatic test_start();
        idle_inputs();
        start_i = 1'b1;
        start_addr_i = 10'h010;
        tick();
        start_i = 1'b0;
        checks++;
        if (running_o !== 1'b1 || imem_addr_o !== 10'h010) begin
            errors++;
            $display("FAIL start got run=%b addr=%h want 1/010",
                     running_o, imem_addr_o);
        end
        checks++;
        if (instruction_o !== imem_data_i) begin
            errors++;
            $display("FAIL run_insn got %h want %h",
                     instruction_o, imem_data_i);
        end
        repeat (3) begin
            idle_inputs();
            tick();
        end
        checks++;
        if (pc_o !== 10'h013 || cycle_count_o !== 16'd3) begin
            errors++;
            $display("FAIL straight got pc=%h cnt=%0d want 013/3",
                     pc_o, cycle_count_o);
        end
    endtask

    task automatic test_branches();
        idle_inputs();
        branchf_i = 1'b1; offset_i = 8'h0D;
        tick();
        checks++;
        if (pc_o !== 10'h020) begin
            errors++;
            $display("FAIL bf_to20 got %h want 020", pc_o);
        end
        idle_inputs();
        branchf_i = 1'b1; offset_i = 8'd5;
        tick();
        checks++;
        if (pc_o !== 10'h025) begin
            errors++;
            $display("FAIL bf5 got %h want 025", pc_o);
        end
        idle_inputs();
        branchb_i = 1'b1; offset_i = 8'h25;
        tick();
        checks++;
        if (pc_o !== 10'h000) begin
            errors++;
            $display("FAIL bb25 got %h want 000", pc_o);
        end
        idle_inputs();
        branchb_i = 1'b1; branchf_i = 1'b1; offset_i = 8'd2;
        tick();
        checks++;
        if (pc_o !== 10'h002) begin
            errors++;
            $display("FAIL bf_over_bb got %h want 002", pc_o);
        end
        idle_inputs();
        branchb_i = 1'b1; offset_i = 8'd3;
        tick();
        checks++;
        if (pc_o !== 10'h3FF) begin
            errors++;
            $display("FAIL bb_wrap got %h want 3ff", pc_o);
        end
        idle_inputs();
        branchf_i = 1'b1; offset_i = 8'd0;
        tick();
        checks++;
        if (pc_o !== 10'h3FF) begin
            errors++;
            $display("FAIL self_loop got %h want 3ff", pc_o);
        end
        idle_inputs();
        tick();
        checks++;
        if (pc_o !== 10'h000) begin
            errors++;
            $display("FAIL seq_wrap got %h want 000", pc_o);
        end
    endtask

    task automatic test_halt();
        int cnt_h;
        idle_inputs();
        branchf_i = 1'b1; offset_i = 8'h40;
        tick();
        idle_inputs();
        done_i = 1'b1; branchf_i = 1'b1; offset_i = 8'd5;
        imem_data_i = 8'h11;
        tick();
        cnt_h = m_cnt;
        checks++;
        if (pc_o !== 10'h040 || done_o !== 1'b1 || running_o !== 1'b0) begin
            errors++;
            $display("FAIL halt got pc=%h done=%b run=%b want 040/1/0",
                     pc_o, done_o, running_o);
        end
        checks++;
        if (instruction_o !== 8'h88 || cycle_count_o !== 16'(cnt_h)) begin
            errors++;
            $display("FAIL halt_insn got %h cnt=%0d want 88/%0d",
                     instruction_o, cycle_count_o, cnt_h);
        end
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            branchf_i = 1'($urandom); branchb_i = 1'($urandom);
            done_i = 1'($urandom);
            offset_i = 8'($urandom_range(1, 255));
            tick();
            checks++;
            if (pc_o !== 10'h040 || cycle_count_o !== 16'(cnt_h)
                || done_o !== 1'b1) begin
                errors++;
                $display("FAIL halt_frozen[%0d] got pc=%h cnt=%0d want 040/%0d",
                         i, pc_o, cycle_count_o, cnt_h);
            end
        end
    endtask

    task automatic test_restart_ignore();
        idle_inputs();
        start_i = 1'b1; start_addr_i = 10'h100;
        tick();
        checks++;
        if (pc_o !== 10'h100 || cycle_count_o !== 16'd0
            || running_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL restart got pc=%h cnt=%0d run=%b done=%b want 100/0/1/0",
                     pc_o, cycle_count_o, running_o, done_o);
        end
        idle_inputs();
        start_i = 1'b1; start_addr_i = 10'h200;
        tick();
        start_i = 1'b0;
        checks++;
        if (pc_o !== 10'h101 || cycle_count_o !== 16'd1) begin
            errors++;
            $display("FAIL start_in_run got pc=%h cnt=%0d want 101/1",
                     pc_o, cycle_count_o);
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        branchf_i = 1'b1; offset_i = 8'h54;
        tick();
        checks++;
        if (pc_o !== 10'h155) begin
            errors++;
            $display("FAIL pre_reset got %h want 155", pc_o);
        end
        idle_inputs();
        @(negedge clk_i);
        reset_i = 1'b1;
        model_reset();
        #1;
        checks++;
        if (pc_o !== 10'h000 || running_o !== 1'b0 || done_o !== 1'b0
            || instruction_o !== 8'h88 || cycle_count_o !== 16'd0) begin
            errors++;
            $display("FAIL async_reset got pc=%h run=%b done=%b insn=%h cnt=%0d",
                     pc_o, running_o, done_o, instruction_o, cycle_count_o);
        end
        start_i = 1'b1; start_addr_i = 10'h0AA;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        idle_inputs();
        repeat (3) tick();
        checks++;
        if (running_o !== 1'b0 || pc_o !== 10'h000) begin
            errors++;
            $display("FAIL stay_idle got run=%b pc=%h want 0/000",
                     running_o, pc_o);
        end
    endtask

    task automatic test_saturation();
        idle_inputs();
        start_i = 1'b1; start_addr_i = 10'h300;
        tick();
        for (int i = 0; i < 20; i++) begin
            idle_inputs();
            tick();
        end
        checks++;
        if (s_cnt !== 4'hF) begin
            errors++;
            $display("FAIL sat4 got %h want f", s_cnt);
        end
        checks++;
        if (cycle_count_o !== 16'd20 || s_pc !== pc_o) begin
            errors++;
            $display("FAIL sat16 got cnt=%0d pc4=%h want 20/%h",
                     cycle_count_o, s_pc, pc_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            start_i   = ($urandom_range(0, 9) == 0);
            start_addr_i = 10'($urandom);
            branchf_i = ($urandom_range(0, 3) == 0);
            branchb_i = ($urandom_range(0, 3) == 0);
            done_i    = ($urandom_range(0, 19) == 0);
            offset_i  = 8'($urandom);
            tick();
            checks++;
            if (pc_o !== 10'(m_pc) || imem_addr_o !== 10'(m_pc)) begin
                errors++;
                $display("FAIL rnd_pc[%0d] got %h want %h", i, pc_o, 10'(m_pc));
            end
            checks++;
            if (cycle_count_o !== 16'(m_cnt) || s_cnt !== 4'(m_cnt4)) begin
                errors++;
                $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d",
                         i, cycle_count_o, s_cnt, m_cnt, m_cnt4);
            end
            checks++;
            if (running_o !== m_run || done_o !== m_halt) begin
                errors++;
                $display("FAIL rnd_state[%0d] got %b%b want %b%b",
                         i, running_o, done_o, m_run, m_halt);
            end
            checks++;
            if (instruction_o !== (m_run ? imem_data_i : 8'h88)) begin
                errors++;
                $display("FAIL rnd_insn[%0d] got %h run=%b", i,
                         instruction_o, m_run);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_branches();
        test_halt();
        test_restart_ignore();
        test_async_reset();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 10, giving the program-counter width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the cycle-counter width in bits.
REQ-003 Port clk_i, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_i, input, 1: reset, asynchronous and active-high.
REQ-005 Port start_i, input, 1: start request for a program run.
REQ-006 Port start_addr_i, input, PC_W: program entry address.
REQ-007 Port imem_data_i, input, 8: instruction byte returned by instruction memory; the memory read is combinational.
REQ-008 Port branchf_i, input, 1: taken forward branch, from the decoder.
REQ-009 Port branchb_i, input, 1: taken backward branch, from the decoder.
REQ-010 Port offset_i, input, 8: unsigned branch distance, taken from register-file read data.
REQ-011 Port done_i, input, 1: halt decoded.
REQ-012 Port imem_addr_o, output, PC_W: instruction-memory address.
REQ-013 Port instruction_o, output, 8: instruction byte presented to the decoder.
REQ-014 Port running_o, output, 1: high while in state RUN.
REQ-015 Port done_o, output, 1: high while in state HALT.
REQ-016 Port pc_o, output, PC_W: current program counter.
REQ-017 Port cycle_count_o, output, CNT_W: number of cycles spent in RUN.

Function
REQ-018 The block SHALL implement three states: IDLE, RUN and HALT.
REQ-019 State transitions SHALL be:
  - IDLE to RUN on start_i.
  - RUN to HALT on done_i.
  - HALT to RUN on start_i.
  - All other cases hold the current state.
REQ-020 On the edge that samples start_i in IDLE or HALT, the block SHALL load pc from start_addr_i and clear cycle_count to 0.
REQ-021 start_i SHALL be ignored while in RUN.
REQ-022 imem_addr_o and pc_o SHALL equal pc combinationally, with zero latency.
REQ-023 instruction_o SHALL equal imem_data_i in RUN, and 8'h88 (halt encoding) in IDLE and HALT.
REQ-024 The pc update in RUN SHALL follow this priority, first match wins:
  - done_i: hold pc.
  - branchf_i: pc + offset_i.
  - branchb_i: pc - offset_i.
  - otherwise: pc + 1.
REQ-025 Branch arithmetic SHALL zero-extend offset_i to PC_W and wrap modulo 2^PC_W.
REQ-026 Sequential increment from the maximum address SHALL wrap to 0.
REQ-027 An offset of 0 SHALL hold pc, producing a deliberate self-loop.
REQ-028 branchf_i, branchb_i and done_i SHALL be ignored outside RUN.
REQ-029 In RUN, cycle_count SHALL increment by 1 per cycle, including the cycle in which done_i is sampled.
REQ-030 cycle_count SHALL saturate at all-ones and not wrap.
REQ-031 In HALT, pc and cycle_count SHALL remain frozen and readable.
REQ-032 running_o and done_o SHALL be registered state decodes, and SHALL never be high together.

Reset
REQ-033 Assertion of reset_i SHALL immediately force:
  - state to IDLE
  - pc to 0
  - cycle_count to 0
  - running_o to 0
  - done_o to 0
  - instruction_o to 8'h88
REQ-034 Reset asserted mid-RUN SHALL abandon the run with no further pc update.
REQ-035 After reset deassertion, the block SHALL remain in IDLE until start_i is sampled high.

Verification
REQ-036 Reset then start: pulse start_i with start_addr_i=0x010 -> next cycle running_o=1, imem_addr_o=0x010; after 3 straight-line cycles pc=0x013 and cycle_count_o=3.
REQ-037 Branches: at pc=0x020, branchf_i=1 with offset_i=5 -> pc=0x025; at pc=0x025, branchb_i=1 with offset_i=0x25 -> pc=0x000; at pc=0x002, branchb_i=1 with offset_i=3 -> pc=0x3FF (wrap).
REQ-038 Halt: done_i=1 together with branchf_i=1 at pc=0x040 -> pc stays 0x040, done_o=1, running_o=0, instruction_o=0x88; pc and count remain frozen for 10 further cycles.
REQ-039 Restart and ignore: start_i in HALT with start_addr_i=0x100 -> RUN at 0x100 with count cleared; start_i during RUN -> no effect on pc or count.
REQ-040 Async reset mid-run: assert reset_i between clock edges at pc=0x155 -> outputs go to reset values before the next edge.
REQ-041 Saturation: with CNT_W=4, run for 20 cycles -> cycle_count_o holds at 0xF.
